// File: rtl/common_types_pkg.sv
// Shared types for the memory subsystem: RAM handshake state, arbiter state,
// latched request bundle and the requester priority pick.
package common_types_pkg;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_WEN_W  = MEM_DATA_W / 8;

   typedef enum logic [1:0] {
      RAM_IDLE,
      RAM_WAIT,
      RAM_DONE
   } ram_state_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_IBUSY,
      ARB_DBUSY
   } arb_state_t;

   typedef struct packed {
      logic                  ren;
      logic [MEM_WEN_W-1:0]  wen;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] store;
   } arb_req_t;

   // Data wins unless both sides are pending and the instruction side is preferred.
   function automatic logic grant_data(input logic i_pend,
                                       input logic d_pend,
                                       input logic prefer_i);
      return d_pend && !(i_pend && prefer_i);
   endfunction

endpackage

// File: rtl/mem_arb_if.sv
// RAM-side bundle (ram_if) and the core-side bundle of the arbiter (mem_arb_if).
// The arbiter drives ram_if.ctrl; the RAM block keeps using ram_if.ram.
interface ram_if
   import common_types_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
);
   logic              ren;
   logic [3:0]        wen;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] store;
   logic [DATA_W-1:0] load;
   ram_state_t        state;

   modport ctrl (output ren, wen, addr, store, input load, state);
   modport ram  (input ren, wen, addr, store, output load, state);
endinterface

interface mem_arb_if
   import common_types_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
);
   logic              i_ren;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_load;
   logic              i_ready;
   logic              d_ren;
   logic [3:0]        d_wen;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_store;
   logic [DATA_W-1:0] d_load;
   logic              d_ready;

   modport arb (
      input  i_ren, i_addr, d_ren, d_wen, d_addr, d_store,
      output i_load, i_ready, d_load, d_ready
   );
   modport ifetch (output i_ren, i_addr, input i_load, i_ready);
   modport lsu (
      output d_ren, d_wen, d_addr, d_store,
      input  d_load, d_ready
   );
endinterface

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter in front of the single-port RAM.
// MEM_ARB_ROUND_ROBIN_EN: alternate grants when both sides are pending.
module mem_arbiter
   import common_types_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              i_ren,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_load,
   output logic              i_ready,
   input  logic              d_ren,
   input  logic [3:0]        d_wen,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_store,
   output logic [DATA_W-1:0] d_load,
   output logic              d_ready,
   output logic              ram_ren,
   output logic [3:0]        ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_store,
   input  logic [DATA_W-1:0] ram_load,
   input  ram_state_t        ram_state
);

   arb_state_t state, nstate;
   arb_req_t   req_q, win, cur;
   logic       i_pend, d_pend, pick_d, prefer_i, done;

   assign i_pend = i_ren;
   assign d_pend = d_ren | (|d_wen);
   assign done   = (ram_state == RAM_DONE);
   assign pick_d = grant_data(i_pend, d_pend, prefer_i);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_d;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         last_d <= 1'b0;
      else if (state == ARB_IDLE && (i_pend || d_pend))
         last_d <= pick_d;
   end

   assign prefer_i = last_d;
`else
   assign prefer_i = 1'b0;
`endif

   always_comb begin
      if (pick_d)
         win = '{ren: d_ren, wen: d_wen, addr: d_addr, store: d_store};
      else
         win = '{ren: i_ren, wen: 4'h0, addr: i_addr, store: '0};
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         state <= ARB_IDLE;
      else
         state <= nstate;
   end

   // Refreshed every idle cycle; frozen for the whole transaction.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         req_q <= '0;
      else if (state == ARB_IDLE)
         req_q <= win;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         ARB_IDLE: begin
            if (pick_d)
               nstate = ARB_DBUSY;
            else if (i_pend)
               nstate = ARB_IBUSY;
         end
         ARB_IBUSY, ARB_DBUSY: begin
            if (done)
               nstate = ARB_IDLE;
         end
         default: nstate = ARB_IDLE;
      endcase
   end

   assign cur = (state == ARB_IDLE) ? win : req_q;

   always_comb begin
      ram_ren   = 1'b0;
      ram_wen   = 4'h0;
      ram_addr  = cur.addr;
      ram_store = cur.store;
      i_ready   = 1'b0;
      d_ready   = 1'b0;
      i_load    = '0;
      d_load    = '0;
      unique case (state)
         ARB_IDLE: begin
            ram_ren = win.ren;
            ram_wen = win.wen;
         end
         ARB_IBUSY: begin
            ram_ren = req_q.ren;
            ram_wen = req_q.wen;
            i_load  = ram_load;
            i_ready = done;
         end
         ARB_DBUSY: begin
            ram_ren = req_q.ren;
            ram_wen = req_q.wen;
            d_load  = ram_load;
            d_ready = done;
         end
         default: ;
      endcase
      // Requests still held during reset must not reach the RAM.
      if (!nrst) begin
         ram_ren = 1'b0;
         ram_wen = 4'h0;
         i_ready = 1'b0;
         d_ready = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a latency-configurable RAM model.
// Build with MEM_ARB_ROUND_ROBIN_EN to check the alternating-grant variant.
module tb_mem_arbiter;
   import common_types_pkg::*;

   typedef struct {
      bit          wr;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] store;
      int          exp;
   } txn_t;

   logic        clk = 1'b0;
   logic        nrst;
   logic        i_ren, d_ren;
   logic [31:0] i_addr, d_addr, d_store;
   logic [3:0]  d_wen;
   logic [31:0] i_load, d_load;
   logic        i_ready, d_ready;
   logic        ram_ren;
   logic [3:0]  ram_wen;
   logic [31:0] ram_addr, ram_store, ram_load;
   ram_state_t  ram_state;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int lat = 0;

   txn_t iq[$];
   txn_t dq[$];
   txn_t mt;

   logic [31:0] mem  [0:255];
   logic [31:0] refm [0:255];

   mem_arbiter dut (
      .clk(clk), .nrst(nrst),
      .i_ren(i_ren), .i_addr(i_addr), .i_load(i_load), .i_ready(i_ready),
      .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_store(d_store),
      .d_load(d_load), .d_ready(d_ready),
      .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
      .ram_store(ram_store), .ram_load(ram_load), .ram_state(ram_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] seed_word(input int k);
      return (32'(k) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      a = $urandom;
      a[9:2] = 8'($urandom_range(0, 15));
      return a;
   endfunction

   // RAM model: samples the request mid-cycle, updates its state after the edge.
   int          rcnt;
   bit          rbusy = 0;
   logic [7:0]  ridx;
   logic [31:0] rdata;
   ram_state_t  rnext;

   initial begin
      for (int k = 0; k < 256; k++) begin
         mem[k]  = seed_word(k);
         refm[k] = seed_word(k);
      end
      ram_state = RAM_IDLE;
      ram_load  = 32'h0;
      rdata     = 32'h0;
      forever begin
         @(negedge clk);
         if (!nrst || ram_state == RAM_DONE) begin
            rbusy = 0;
            rnext = RAM_IDLE;
         end else if (rbusy) begin
            rcnt--;
            rnext = (rcnt == 0) ? RAM_DONE : RAM_WAIT;
         end else if (ram_ren || ram_wen != 4'h0) begin
            rbusy = 1;
            rcnt  = lat;
            ridx  = ram_addr[9:2];
            for (int b = 0; b < 4; b++)
               if (ram_wen[b]) mem[ridx][8*b +: 8] = ram_store[8*b +: 8];
            rdata = mem[ridx];
            rnext = (rcnt == 0) ? RAM_DONE : RAM_WAIT;
         end else begin
            rnext = RAM_IDLE;
         end
         @(posedge clk);
         #1;
         ram_state = rnext;
         ram_load  = (rnext == RAM_DONE) ? rdata : 32'hBAD0_BAD0;
      end
   end

   // Monitor: every ready pops the owner's oldest expectation.
   always @(negedge clk) begin
      if (nrst && (i_ready || d_ready)) begin
         chk("ready_exclusive", 32'(i_ready & d_ready), 32'h0);
         if (d_ready) begin
            if (dq.size() == 0) begin
               chk("d_ready_unexpected", 32'h1, 32'h0);
            end else begin
               mt = dq.pop_front();
               if (mt.exp >= 0) chk("d_ready_cycle", 32'(cyc), 32'(mt.exp));
               chk("i_load_nonowner", i_load, 32'h0);
               if (mt.wr) begin
                  for (int b = 0; b < 4; b++)
                     if (mt.wen[b])
                        refm[mt.addr[9:2]][8*b +: 8] = mt.store[8*b +: 8];
               end else begin
                  chk("d_load", d_load, refm[mt.addr[9:2]]);
               end
            end
         end
         if (i_ready) begin
            if (iq.size() == 0) begin
               chk("i_ready_unexpected", 32'h1, 32'h0);
            end else begin
               mt = iq.pop_front();
               if (mt.exp >= 0) chk("i_ready_cycle", 32'(cyc), 32'(mt.exp));
               chk("d_load_nonowner", d_load, 32'h0);
               chk("i_load", i_load, refm[mt.addr[9:2]]);
            end
         end
      end
   end

   task automatic wait_rdy(input bit is_d);
      bit got = 0;
      for (int k = 0; k < 400 && !got; k++) begin
         @(negedge clk);
         got = is_d ? d_ready : i_ready;
      end
      if (!got) begin
         chk(is_d ? "d_ready_timeout" : "i_ready_timeout", 32'h0, 32'h1);
         if (is_d && dq.size() > 0) dq.delete(0);
         if (!is_d && iq.size() > 0) iq.delete(0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue_d(input bit wr, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] store,
                          input int exp);
      txn_t t;
      d_ren   = !wr;
      d_wen   = wr ? wen : 4'h0;
      d_addr  = addr;
      d_store = store;
      t.wr = wr; t.wen = wen; t.addr = addr; t.store = store; t.exp = exp;
      dq.push_back(t);
   endtask

   task automatic issue_i(input logic [31:0] addr, input int exp);
      txn_t t;
      i_ren  = 1'b1;
      i_addr = addr;
      t.wr = 0; t.wen = 4'h0; t.addr = addr; t.store = 32'h0; t.exp = exp;
      iq.push_back(t);
   endtask

   task automatic d_txn(input bit wr, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] store,
                        input int exp);
      issue_d(wr, wen, addr, store, exp);
      wait_rdy(1'b1);
   endtask

   task automatic i_txn(input logic [31:0] addr, input int exp);
      issue_i(addr, exp);
      wait_rdy(1'b0);
   endtask

   task automatic d_idle();
      d_ren = 1'b0;
      d_wen = 4'h0;
   endtask

   // Slot s of a saturated stream completes at base + s*(lat+2) + lat + 1.
   task automatic run_d(input int n, input int first, input int stride,
                        input int base, input int lt, input int gapmax);
      for (int k = 0; k < n; k++) begin
         bit         wr;
         logic [3:0] wen;
         int         e, g;
         wr  = 1'($urandom_range(0, 1));
         wen = wr ? 4'($urandom_range(1, 15)) : 4'h0;
         e   = (base < 0) ? -1 : base + (first + k*stride)*(lt + 2) + lt + 1;
         d_txn(wr, wen, rnd_addr(), $urandom, e);
         g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
         if (g > 0) begin
            d_idle();
            repeat (g) begin @(posedge clk); #1; end
         end
      end
      d_idle();
   endtask

   task automatic run_i(input int n, input int first, input int stride,
                        input int base, input int lt, input int gapmax);
      for (int k = 0; k < n; k++) begin
         int e, g;
         e = (base < 0) ? -1 : base + (first + k*stride)*(lt + 2) + lt + 1;
         i_txn(rnd_addr(), e);
         g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
         if (g > 0) begin
            i_ren = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
         end
      end
      i_ren = 1'b0;
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      iq.delete();
      dq.delete();
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      nrst = 1'b0;
      i_ren = 1'b0; i_addr = 32'h0;
      d_ren = 1'b0; d_wen = 4'h0; d_addr = 32'h0; d_store = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ram_ren", 32'(ram_ren), 32'h0);
      chk("rst_ram_wen", 32'(ram_wen), 32'h0);
      chk("rst_i_ready", 32'(i_ready), 32'h0);
      chk("rst_d_ready", 32'(d_ready), 32'h0);
      nrst = 1'b1;
      @(posedge clk);
      #1;

      // Instruction read, zero latency
      lat = 0;
      n = cyc;
      issue_i(32'h10, n + 1);
      @(negedge clk);
      chk("t1_ram_ren", 32'(ram_ren), 32'h1);
      chk("t1_ram_addr", ram_addr, 32'h10);
      wait_rdy(1'b0);
      i_ren = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // Partial store then readback, latency 2
      lat = 2;
      n = cyc;
      issue_d(1'b1, 4'b0011, 32'h20, 32'hDEAD_BEEF, n + 3);
      @(negedge clk);
      chk("t2_ram_store", ram_store, 32'hDEAD_BEEF);
      wait_rdy(1'b1);
      n = cyc;
      d_txn(1'b0, 4'h0, 32'h20, 32'h0, n + 3);
      d_idle();

      // Simultaneous requests: data first, instruction lat+2 later
      lat = 1;
      do_reset();
      n = cyc;
      fork
         begin d_txn(1'b0, 4'h0, 32'h30, 32'h0, n + 2); d_idle(); end
         begin i_txn(32'h34, n + 5); i_ren = 1'b0; end
      join

      // Both sides saturated for six transactions
      do_reset();
      n = cyc;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      fork
         run_d(3, 0, 2, n, 1, 0);
         run_i(3, 1, 2, n, 1, 0);
      join
`else
      fork
         run_d(6, 0, 1, n, 1, 0);
         run_i(1, 6, 1, n, 1, 0);
      join
`endif

      // Requester changes address mid-transaction, latency 3
      lat = 3;
      n = cyc;
      issue_d(1'b0, 4'h0, 32'h24, 32'h0, n + 4);
      @(posedge clk);
      #1 d_addr = 32'h40;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("t5_ram_addr_held", ram_addr, 32'h24);
         if (d_ready) break;
      end
      @(posedge clk);
      #1 d_idle();

      // Reset during a data transaction
      n = cyc;
      issue_d(1'b0, 4'h0, 32'h28, 32'h0, n + 4);
      @(posedge clk);
      #2 chk("t6_busy_ren", 32'(ram_ren), 32'h1);
      nrst = 1'b0;
      dq.delete();
      #1;
      chk("t6_ram_ren", 32'(ram_ren), 32'h0);
      chk("t6_ram_wen", 32'(ram_wen), 32'h0);
      chk("t6_i_ready", 32'(i_ready), 32'h0);
      chk("t6_d_ready", 32'(d_ready), 32'h0);
      d_idle();
      repeat (2) @(posedge clk);
      #3 nrst = 1'b1;
      #1 chk("t6_idle_ren", 32'(ram_ren), 32'h0);
      @(posedge clk);
      #1;
      n = cyc;
      i_txn(32'h2C, n + 4);
      i_ren = 1'b0;

      // Randomised traffic at each latency
      for (int lt = 0; lt < 4; lt++) begin
         lat = lt;
         repeat (2) begin @(posedge clk); #1; end
         fork
            run_d(25, 0, 0, -1, lt, 3);
            run_i(25, 0, 0, -1, lt, 3);
         join
      end

      repeat (6) @(posedge clk);
      #1;
      chk("iq_drained", 32'(iq.size()), 32'h0);
      chk("dq_drained", 32'(dq.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sitting directly upstream of the single-port RAM block.
- Multiplexes the core's instruction-fetch port and data (load/store) port onto one RAM interface (ren, byte wen, addr, store, load, state).
- Grants one requester at a time and latches the granted request for the whole transaction.
- Returns load data and a one-cycle ready pulse to the granted requester when the RAM reports RAM_DONE.

Parameters:
- ADDR_W, 32, byte-address width on all ports.
- DATA_W, 32, data width; must be 32 (4 byte lanes).

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- i_ren  in  1  instruction read request
- i_addr  in  ADDR_W  instruction byte address
- i_load  out  DATA_W  instruction read data, valid when i_ready=1
- i_ready  out  1  instruction transaction complete (1-cycle pulse)
- d_ren  in  1  data read request
- d_wen  in  4  data byte write enables
- d_addr  in  ADDR_W  data byte address
- d_store  in  DATA_W  data write data
- d_load  out  DATA_W  data read data, valid when d_ready=1
- d_ready  out  1  data transaction complete (1-cycle pulse)
- ram_ren  out  1  RAM read enable
- ram_wen  out  4  RAM byte write enables
- ram_addr  out  ADDR_W  RAM address
- ram_store  out  DATA_W  RAM write data
- ram_load  in  DATA_W  RAM read data
- ram_state  in  ram_state_t  RAM_IDLE / RAM_WAIT / RAM_DONE

Behaviour:
- FSM states (arb_state_t): ARB_IDLE, ARB_IBUSY, ARB_DBUSY. Reset state is ARB_IDLE.
- A request is pending when i_ren=1 (instruction side) or when d_ren=1 or |d_wen (data side).
- ARB_IDLE:
  - Winner selection: data wins over instruction (fixed priority).
  - The winner's ren/wen/addr/store drive the RAM combinationally in the same cycle.
  - The winner's fields are latched into request registers at the clock edge.
  - Transition to ARB_DBUSY or ARB_IBUSY. No request: stay in ARB_IDLE and drive ram_ren=0, ram_wen=0.
- ARB_xBUSY:
  - The RAM is driven only from the latched registers; requester changes are ignored until completion.
  - When ram_state==RAM_DONE: assert x_ready for exactly that cycle and return to ARB_IDLE.
  - RAM enables stay asserted through the DONE cycle and are deasserted in the following cycle.
- Latency:
  - A request accepted in cycle N yields ready in cycle N+LAT+1, where LAT is the RAM parameter (N+1 when LAT=0).
  - Back-to-back accesses cost LAT+2 cycles each, because of one ARB_IDLE re-arbitration cycle.
- Load data:
  - x_load = ram_load, routed combinationally to the owner.
  - The non-owner load output is driven to 0.
  - d_load is don't-care for writes.
- Ready:
  - i_ready and d_ready are never asserted together.
  - Neither is asserted in ARB_IDLE.
- Simultaneous requests:
  - The data request is served first.
  - The instruction request must stay asserted and is granted on the next ARB_IDLE cycle.
- Requester obligations:
  - A requester holds its request until it sees ready, then deasserts or presents a new request on the following cycle.
  - A request dropped mid-transaction still completes on the RAM and still pulses ready.
- ram_state of RAM_DONE seen while in ARB_IDLE is ignored.
- Reset (asynchronous, including mid-transaction):
  - FSM returns to ARB_IDLE; request registers clear to 0.
  - All ready outputs and RAM enables go to 0 immediately.
  - No partial ready pulse is generated.
- Write data is passed through unmodified; no byte shifting is performed in this block.
- Widths:
  - ram_addr equals the full latched address; the RAM uses only [31:2].
  - Unaligned low address bits pass through untouched.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Adds a 1-bit last-grant register, reset to instruction.
  - When both sides are pending in ARB_IDLE, the side not granted last wins. This bounds starvation to one transaction.
  - A single pending requester always wins regardless of last-grant.
- Undefined: fixed data-over-instruction priority; the last-grant register is absent.

Decomposition:
- Add arb_state_t (ARB_IDLE, ARB_IBUSY, ARB_DBUSY) to common_types_pkg, beside ram_state_t.
- Add arb_req_t struct {ren, wen[3:0], addr, store} to common_types_pkg.
- Define mem_arb_if (instruction side, data side, RAM side) alongside ram_if. The RAM side must connect to ram_if.ram unchanged.
- No sub-module: the priority pick is a small function; the request latch is one always_ff.

Test Plan:
- LAT=0, instruction read:
  - i_ren=1, i_addr=0x00000010 in cycle N.
  - Expect ram_ren=1 and ram_addr=0x10 in cycle N.
  - Expect i_ready=1 in cycle N+1, with i_load equal to the RAM word at index 4.
- LAT=2, data store:
  - d_wen=4'b0011, d_addr=0x20, d_store=0xDEADBEEF.
  - Expect d_ready in cycle N+3.
  - A subsequent d_ren at 0x20 returns the low half 0xBEEF merged with the prior upper bytes.
- Simultaneous requests:
  - i_ren and d_ren both asserted in the same cycle (macro undefined).
  - Expect d_ready first, then i_ready LAT+2 cycles later, never in the same cycle.
- Starvation (MEM_ARB_ROUND_ROBIN_EN defined):
  - Hold both requests for 6 transactions.
  - Expect grants to alternate D,I,D,I,D,I.
  - With the macro undefined, expect all 6 grants to data.
- Mutation mid-transaction:
  - LAT=3; change d_addr to 0x40 one cycle after grant.
  - Expect ram_addr to hold the original address until d_ready.
- Reset mid-transaction:
  - Pulse nrst low during ARB_DBUSY.
  - Expect ram_ren, ram_wen, i_ready and d_ready to drop to 0 immediately and the FSM to return to ARB_IDLE.
  - Expect a new i_ren after reset to complete normally.
